// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared sequencer state encoding and core-wide constants
// Opcode constants are shared with the control unit.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } seq_state_t;

   localparam int INSTR_WIDTH = 32;
   localparam int PC_INCR     = 4;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - next-PC adder and taken-target alignment check
// Only taken targets are checked; pc + 4 from an aligned pc is always aligned.
module pc_next
   import riscv_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic [ADDR_WIDTH-1:0] imm_op,
   input  logic                  pc_src,
   output logic [ADDR_WIDTH-1:0] target,
   output logic                  misaligned
);

   always_comb begin
      target     = pc_src ? (pc + imm_op) : (pc + ADDR_WIDTH'(PC_INCR));
      misaligned = pc_src && (target[1:0] != 2'b00);
   end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle fetch/commit sequencer owning the PC
// Optional macro HALT_ON_SELF_LOOP_EN: a committed branch-to-self parks the sequencer in HALT.
module fetch_sequencer
   import riscv_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  instr_valid,
   input  logic                  pc_src,
   input  logic [ADDR_WIDTH-1:0] imm_op,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [CNT_WIDTH-1:0]  retired,
   output logic                  halted,
   output logic                  misalign
);

   seq_state_t              state;
   seq_state_t              state_nxt;
   logic                    load_instr;
   logic                    commit;
   logic                    set_mis;
   logic [ADDR_WIDTH-1:0]   target;
   logic                    target_mis;

   pc_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc_next (
      .pc         (pc),
      .imm_op     (imm_op),
      .pc_src     (pc_src),
      .target     (target),
      .misaligned (target_mis)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      load_instr  = 1'b0;
      commit      = 1'b0;
      set_mis     = 1'b0;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      halted      = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_nxt = FETCH;
         end
         FETCH: begin
            // en is ignored here so an issued request always completes
            imem_req = 1'b1;
            if (imem_ack) begin
               load_instr = 1'b1;
               state_nxt  = EXEC;
            end
         end
         EXEC: begin
            instr_valid = 1'b1;
            if (target_mis) begin
               set_mis   = 1'b1;
               state_nxt = HALT;
            end else begin
               commit    = 1'b1;
               state_nxt = en ? FETCH : IDLE;
`ifdef HALT_ON_SELF_LOOP_EN
               if (pc_src && (imm_op == '0)) state_nxt = HALT;
`endif
            end
         end
         HALT: begin
            halted = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         instr    <= '0;
         retired  <= '0;
         misalign <= 1'b0;
      end else begin
         if (load_instr) instr <= imem_rdata;
         if (commit) begin
            pc      <= target;
            retired <= retired + CNT_WIDTH'(1);
         end
         if (set_mis) misalign <= 1'b1;
      end
   end

   assign imem_addr = pc;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle fetch/commit sequencer for the reduced RISC-V core. It owns the PC and runs the instruction-memory request/acknowledge handshake. It presents each fetched instruction to the control unit and datapath for exactly one commit cycle, then samples the branch decision (pc_src) and the extended immediate to form the next PC. It sits between the instruction memory and the control unit / register file, and gates all architectural updates via instr_valid.

Parameters:
ADDR_WIDTH, 32, width of PC and instruction-memory address
DATA_WIDTH, 32, instruction width
RESET_PC, 0, PC value loaded on reset
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
en  in  1  run enable; low parks the sequencer in IDLE between instructions
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_WIDTH  fetch address, equals pc
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  DATA_WIDTH  fetched instruction
instr  out  DATA_WIDTH  latched instruction to control unit / datapath
instr_valid  out  1  commit strobe; RegWrite is qualified by this
pc_src  in  1  branch taken, from control unit, sampled when instr_valid=1
imm_op  in  ADDR_WIDTH  sign-extended immediate, sampled when instr_valid=1
pc  out  ADDR_WIDTH  current PC
retired  out  CNT_WIDTH  count of committed instructions
halted  out  1  sequencer in HALT
misalign  out  1  sticky: branch target not word-aligned

Behaviour:
- Clock clk, reset rst: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired=0, halted=0, misalign=0. Reset overrides everything, including mid-handshake. An imem_ack in any cycle where imem_req=0 is ignored.
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE: imem_req=0. en=1 -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc, held stable until ack. imem_ack=1 (same cycle as req permitted) -> instr<=imem_rdata, go EXEC. en falling during FETCH does not abort: the request completes and EXEC still occurs.
- EXEC: exactly one cycle, instr_valid=1, imem_req=0.
  - target = pc + imm_op if pc_src else pc + 4, modulo 2^ADDR_WIDTH (wrap silently).
  - Taken target with target[1:0]!=0: pc unchanged, misalign<=1, retired not incremented, go HALT.
  - Otherwise pc<=target, retired<=retired+1 (wraps), next = en ? FETCH : IDLE.
- HALT: halted=1, imem_req=0, instr_valid=0. Only rst exits.
- Throughput: 2 cycles/instruction minimum with zero-wait memory. Each memory wait cycle adds one cycle.
- pc_src and imm_op are don't-care outside EXEC.

Optional Feature:
HALT_ON_SELF_LOOP_EN:
- Defined: in EXEC, pc_src=1 with imm_op=0 (branch-to-self) commits (retired+1, pc unchanged), then goes to HALT with halted=1 and misalign=0.
- Undefined: branch-to-self is an ordinary taken branch that refetches the same PC forever; HALT is reachable only via misalign.

Decomposition:
- Shared package riscv_pkg: seq_state_t enum (IDLE, FETCH, EXEC, HALT), INSTR_WIDTH=32, PC_INCR=4, opcode constants (OP_IMM=7'b0010011, OP_BRANCH=7'b1100011) shared with the control unit.
- Sub-module pc_next: combinational; inputs pc, imm_op, pc_src; outputs target and misaligned flag. Reused later for JAL.

Test Plan:
- Reset then en=1, memory acks same cycle with 0x00100093 -> imem_addr=0 on cycle 1, instr_valid on cycle 2, pc=4, retired=1. Instructions retire every 2 cycles.
- Memory with 3 wait cycles -> imem_req held and imem_addr stable for 4 cycles, single instr_valid pulse, pc advances by 4 only once.
- pc=0x10, EXEC with pc_src=1 and imm_op=0xFFFFFFF8 -> pc=0x08. With pc_src=0 -> pc=0x14. With pc=0xFFFFFFFC and pc_src=0 -> pc wraps to 0.
- pc_src=1, imm_op=0x6 -> misalign=1, halted=1, pc unchanged, retired unchanged. rst clears both.
- en dropped mid-FETCH, ack after 2 cycles -> EXEC completes, then IDLE with imem_req=0. rst asserted in FETCH -> next cycle pc=RESET_PC, imem_req=0, and a late ack is ignored.
- HALT_ON_SELF_LOOP_EN defined, pc_src=1 with imm_op=0 -> retired+1, halted=1. Undefined -> same PC refetched repeatedly and halted stays 0.
